lsu_mem_initiator: RTL

- Load/store initiator between the CPU execute stage and the byte-enabled data memory port: addr, datain, dataout, 3-bit memop, we.
- Accepts one load/store per handshake and drives the memory port with registered signals.
- Waits for synchronous read data and returns a single-cycle response.
- Misaligned halfword/word accesses become a sequence of byte accesses, assembled and extended locally, because the memory port cannot serve them.

---
 rtl/lsu_mem_initiator.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the execute stage and a byte-enabled synchronous data memory port.
// Define LSU_MISALIGN_SPLIT_EN to turn misaligned halfword/word accesses into byte sequences.
module lsu_mem_initiator #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_memop,
    input  logic        req_we,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_memop,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t      r_state, w_state_nxt;
    logic        r_we, r_mem_we, r_fault;
    logic [1:0]  r_lat_cnt;
    logic [2:0]  r_mem_memop;
    logic [31:0] r_mem_addr, r_mem_wdata, r_rdata;
    logic        w_legal, w_mis, w_fault, w_lat_done, w_more, w_next_byte, w_iss_we;
    logic [2:0]  w_iss_memop;
    logic [31:0] w_iss_addr, w_iss_wdata, w_resp_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic        r_split, r_zext;
    logic [1:0]  r_idx, r_last, w_iss_idx;
    logic [7:0]  w_wbyte;
    logic [31:0] r_addr, r_wdata, r_asm, w_asm_nxt, w_split_val;
`endif

    // A request transfers when req_valid && req_ready; req_ready is high only in IDLE,
    // and resp_valid is a single-cycle pulse the consumer must take (no backpressure).
    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_fault = r_fault;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_memop  = r_mem_memop;
    assign mem_we     = r_mem_we;
    assign dbg_state  = r_state;

    always_comb begin
        case (req_memop)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
            default:                                w_legal = 1'b0;
        endcase
        w_mis = ((req_memop[1:0] == 2'b01) && req_addr[0]) ||
                ((req_memop[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
        w_fault = ~w_legal;
        w_more  = r_split && (r_idx != r_last);
`else
        w_fault = ~w_legal | w_mis;
        w_more  = 1'b0;
`endif
        w_lat_done  = (r_lat_cnt == LAT_LAST);
        w_next_byte = w_more && (((r_state == S_ISSUE) && r_we) ||
                                 ((r_state == S_WAIT) && w_lat_done));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = w_fault ? S_RESP : S_ISSUE;
            S_ISSUE: if (!r_we) w_state_nxt = S_WAIT;
                     else if (!w_more) w_state_nxt = S_RESP;
            S_WAIT:  if (w_lat_done) w_state_nxt = w_more ? S_ISSUE : S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory-port values for the access starting next cycle, plus the load result.
    always_comb begin
        w_iss_addr   = req_addr;
        w_iss_wdata  = req_wdata;
        w_iss_memop  = req_memop;
        w_iss_we     = (r_state == S_IDLE) ? req_we : r_we;
        w_resp_rdata = (r_state == S_WAIT) ? mem_rdata : 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
        w_iss_idx = (r_state == S_IDLE) ? 2'd0 : r_idx + 2'd1;
        case (w_iss_idx)
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
        if (r_state != S_IDLE) begin
            w_iss_addr  = r_addr + {30'd0, w_iss_idx};
            w_iss_wdata = {24'd0, w_wbyte};
            w_iss_memop = 3'b100;
        end else if (w_legal && w_mis) begin
            w_iss_wdata = {24'd0, req_wdata[7:0]};
            w_iss_memop = 3'b100;
        end
        w_asm_nxt = r_asm;
        w_asm_nxt[{r_idx, 3'b000} +: 8] = mem_rdata[7:0];
        if (r_last == 2'd3)
            w_split_val = w_asm_nxt;
        else if (r_zext)
            w_split_val = {16'd0, w_asm_nxt[15:0]};
        else
            w_split_val = {{16{w_asm_nxt[15]}}, w_asm_nxt[15:0]};
        if ((r_state == S_WAIT) && r_split)
            w_resp_rdata = w_split_val;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_lat_cnt   <= 2'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_memop <= 3'd0;
            r_mem_we    <= 1'b0;
            r_rdata     <= 32'd0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && req_valid)
                r_we <= req_we;
            r_lat_cnt <= ((r_state == S_WAIT) && !w_lat_done) ? r_lat_cnt + 2'd1 : 2'd0;
            // Address and memop stay put through WAIT: memory dataout is combinational on memop.
            if (w_state_nxt == S_ISSUE) begin
                r_mem_addr  <= w_iss_addr;
                r_mem_wdata <= w_iss_wdata;
                r_mem_memop <= w_iss_memop;
                r_mem_we    <= w_iss_we;
            end else if (w_state_nxt == S_WAIT) begin
                r_mem_we <= 1'b0;
            end else begin
                r_mem_addr  <= 32'd0;
                r_mem_wdata <= 32'd0;
                r_mem_memop <= 3'd0;
                r_mem_we    <= 1'b0;
            end
            r_rdata <= (w_state_nxt == S_RESP) ? w_resp_rdata : 32'd0;
            r_fault <= (w_state_nxt == S_RESP) && (r_state == S_IDLE);
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_split <= 1'b0;
            r_zext  <= 1'b0;
            r_idx   <= 2'd0;
            r_last  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_asm   <= 32'd0;
        end else if ((r_state == S_IDLE) && req_valid) begin
            r_split <= w_legal & w_mis;
            r_zext  <= req_memop[2];
            r_idx   <= 2'd0;
            r_last  <= req_memop[1] ? 2'd3 : 2'd1;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_asm   <= 32'd0;
        end else begin
            if (w_next_byte)
                r_idx <= r_idx + 2'd1;
            if ((r_state == S_WAIT) && w_lat_done)
                r_asm <= w_asm_nxt;
        end
    end
`endif
endmodule
